// File: rtl/dpram_pkg.sv
// Shared definitions for the parametrised dual-port vector RAM.
package dpram_pkg;
  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  localparam int RDW_OLD        = 0;
  localparam int RDW_NEW        = 1;
  localparam int MAX_OUT_STAGES = 2;
  localparam int NUM_PORTS      = 2;
endpackage

// File: rtl/dpram_if.sv
// Two-port RAM bus: per-port address/control/data plus status flags.
interface dpram_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  import dpram_pkg::*;

  logic [ADDR_W-1:0] address_a, address_b;
  logic              wren_a, rden_a, wren_b, rden_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic [DATA_W-1:0] out_a, out_b;
  logic              rvalid_a, rvalid_b;
  logic              busy, collision;

  modport master (
    output address_a, wren_a, rden_a, data_a,
    output address_b, wren_b, rden_b, data_b,
    input  out_a, rvalid_a, out_b, rvalid_b, busy, collision
  );

  modport slave (
    input  address_a, wren_a, rden_a, data_a,
    input  address_b, wren_b, rden_b, data_b,
    output out_a, rvalid_a, out_b, rvalid_b, busy, collision
  );
endinterface

// File: rtl/dpram_out_pipe.sv
// Per-port read-result delay line: valid is registered alongside the RAM read
// register, then valid+data travel STAGES more registers; data holds between reads.
module dpram_out_pipe #(
  parameter int DATA_W = 64,
  parameter int STAGES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);
  if (STAGES == 0) begin : g_bypass
    logic [0:0] vld_pipe;

    always_ff @(posedge clk) begin
      if (reset) vld_pipe <= '0;
      else       vld_pipe <= in_vld;
    end

    assign out_vld  = vld_pipe[0];
    assign out_data = in_data;
  end else begin : g_pipe
    logic [STAGES:0]              vld_pipe;
    logic [STAGES:1][DATA_W-1:0]  dat_pipe;

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_pipe <= '0;
        dat_pipe <= '0;
      end else begin
        vld_pipe[0] <= in_vld;
        for (int s = 1; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
        // data only moves with its valid so each stage keeps the last result
        if (vld_pipe[0]) dat_pipe[1] <= in_data;
        for (int s = 2; s <= STAGES; s++)
          if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end

    assign out_vld  = vld_pipe[STAGES];
    assign out_data = dat_pipe[STAGES];
  end
endmodule

// File: rtl/dpram_param.sv
// Parametrised true dual-port RAM with registered read pipeline, cross-port
// read-during-write policy, dual-write collision flag and post-reset clear.
module dpram_param #(
  parameter int DATA_W         = 64,
  parameter int DEPTH          = 32,
  parameter int ADDR_W         = 5,
  parameter int OUT_STAGES     = 0,
  parameter int RDW_NEW        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic   clk,
  input  logic   reset,
  dpram_if.slave bus
);
  import dpram_pkg::*;

  localparam int              STG       = (OUT_STAGES > MAX_OUT_STAGES) ? MAX_OUT_STAGES : OUT_STAGES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  state_e            state, state_n;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_n;
  logic              port_en;
  logic              collision_q;

  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata, rdata;
  logic [NUM_PORTS-1:0]             wren, rden, in_rng, we, re, rvalid;

  assign addr  = {bus.address_b, bus.address_a};
  assign wdata = {bus.data_b, bus.data_a};
  assign wren  = {bus.wren_b, bus.wren_a};
  assign rden  = {bus.rden_b, bus.rden_a};

  assign bus.out_a     = rdata[0];
  assign bus.out_b     = rdata[1];
  assign bus.rvalid_a  = rvalid[0];
  assign bus.rvalid_b  = rvalid[1];
  assign bus.busy      = (state == ST_CLEAR);
  assign bus.collision = collision_q;

  assign port_en = (state == ST_RUN) && !reset;

  // write wins over read on the same port; out-of-range writes are dropped
  always_comb begin
    in_rng = '0;
    we     = '0;
    re     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_rng[p] = ({1'b0, addr[p]} < DEPTH_LIM);
      we[p]     = port_en && wren[p] && in_rng[p];
      re[p]     = port_en && rden[p] && !wren[p];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt <= '0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    case (state)
      ST_CLEAR: begin
        clr_cnt_n = clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          state_n   = ST_RUN;
          clr_cnt_n = '0;
        end
      end
      default: ;
    endcase
  end

  // storage: plain array, no reset, so it maps onto block RAM
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      // B first so A's data is what remains on a same-address dual write
      if (we[1]) mem[addr[1]] <= wdata[1];
      if (we[0]) mem[addr[0]] <= wdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) collision_q <= 1'b0;
    else       collision_q <= port_en && wren[0] && wren[1] && (addr[0] == addr[1]);
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    localparam int Q = NUM_PORTS - 1 - p;

    logic [DATA_W-1:0] ram_q, fwd_q, stage0;
    logic              fwd_sel_q;

    // read register plus forwarding capture; all hold when no read is issued
    always_ff @(posedge clk) begin
      if (reset) begin
        ram_q     <= '0;
        fwd_q     <= '0;
        fwd_sel_q <= 1'b0;
      end else if (re[p]) begin
        ram_q     <= in_rng[p] ? mem[addr[p]] : '0;
        fwd_q     <= wdata[Q];
        fwd_sel_q <= (RDW_NEW == dpram_pkg::RDW_NEW) && we[Q] && (addr[Q] == addr[p]);
      end
    end

    assign stage0 = fwd_sel_q ? fwd_q : ram_q;

    dpram_out_pipe #(
      .DATA_W (DATA_W),
      .STAGES (STG)
    ) u_pipe (
      .clk      (clk),
      .reset    (reset),
      .in_vld   (re[p]),
      .in_data  (stage0),
      .out_vld  (rvalid[p]),
      .out_data (rdata[p])
    );
  end
endmodule

// File: tb/tb_dpram_param.sv
// Bench for dpram_param: three configurations, scoreboarded read results with
// latency check, plus a vector table for write/read-back traffic.
module tb_dpram_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst2;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int n0, n1;

  dpram_if #(.DATA_W(64), .ADDR_W(5)) if0 ();
  dpram_if #(.DATA_W(64), .ADDR_W(5)) if1 ();
  dpram_if #(.DATA_W(64), .ADDR_W(5)) if2 ();

  dpram_param #(.DATA_W(64), .DEPTH(32), .ADDR_W(5), .OUT_STAGES(2), .RDW_NEW(0), .CLEAR_ON_RESET(1))
    u_dut0 (.clk(clk), .reset(rst0), .bus(if0));
  dpram_param #(.DATA_W(64), .DEPTH(32), .ADDR_W(5), .OUT_STAGES(2), .RDW_NEW(1), .CLEAR_ON_RESET(1))
    u_dut1 (.clk(clk), .reset(rst0), .bus(if1));
  dpram_param #(.DATA_W(64), .DEPTH(20), .ADDR_W(5), .OUT_STAGES(1), .RDW_NEW(0), .CLEAR_ON_RESET(0))
    u_dut2 (.clk(clk), .reset(rst2), .bus(if2));

  // dut1 sees exactly the stimulus of dut0; only the RDW policy differs
  assign if1.address_a = if0.address_a;
  assign if1.wren_a    = if0.wren_a;
  assign if1.rden_a    = if0.rden_a;
  assign if1.data_a    = if0.data_a;
  assign if1.address_b = if0.address_b;
  assign if1.wren_b    = if0.wren_b;
  assign if1.rden_b    = if0.rden_b;
  assign if1.data_b    = if0.data_b;

  typedef struct {logic [63:0] data; int due;} exp_t;
  exp_t sb[6][$];

  typedef struct {logic [4:0] addr; logic [63:0] wdata; logic [63:0] exp;} vec_t;
  vec_t vec[6];

  logic [5:0]       rv;
  logic [5:0][63:0] od;
  assign rv = {if2.rvalid_b, if2.rvalid_a, if1.rvalid_b, if1.rvalid_a, if0.rvalid_b, if0.rvalid_a};
  assign od = {if2.out_b, if2.out_a, if1.out_b, if1.out_a, if0.out_b, if0.out_a};

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void push(int id, logic [63:0] d, int stg);
    exp_t e;
    e.data = d;
    e.due  = cyc + 1 + stg;
    sb[id].push_back(e);
  endfunction

  // monitor: every rvalid must match the head of its queue, on its due cycle
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      if (rv[i]) begin
        if (sb[i].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rvalid_unexpected port%0d: got rvalid=1 required 0 (cycle %0d)", i, cyc);
        end else begin
          e = sb[i].pop_front();
          chk($sformatf("rdata_p%0d", i), od[i], e.data);
          chk($sformatf("rlatency_p%0d", i), 64'(cyc), 64'(e.due));
        end
      end else if (sb[i].size() > 0 && sb[i][0].due <= cyc) begin
        e = sb[i].pop_front();
        checks++;
        failures++;
        $display("FAIL rvalid_missing port%0d: got rvalid=0 required 1 (cycle %0d)", i, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    if0.wren_a = 1'b0; if0.rden_a = 1'b0;
    if0.wren_b = 1'b0; if0.rden_b = 1'b0;
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [63:0] d);
    if0.address_a = a; if0.data_a = d; if0.wren_a = 1'b1;
    step();
    if0.wren_a = 1'b0;
  endtask

  task automatic rd_a(input logic [4:0] a, input logic [63:0] e0, input logic [63:0] e1);
    if0.address_a = a; if0.rden_a = 1'b1;
    push(0, e0, 2); push(2, e1, 2);
    step();
    if0.rden_a = 1'b0;
  endtask

  task automatic rd_b(input logic [4:0] a, input logic [63:0] e0, input logic [63:0] e1);
    if0.address_b = a; if0.rden_b = 1'b1;
    push(1, e0, 2); push(3, e1, 2);
    step();
    if0.rden_b = 1'b0;
  endtask

  task automatic count_busy(output int c0, output int c1);
    c0 = 0; c1 = 0;
    for (int k = 0; k < 100 && (if0.busy || if1.busy); k++) begin
      if (if0.busy) c0++;
      if (if1.busy) c1++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec[0] = '{5'd0,  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vec[1] = '{5'd31, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_0000_FFFF_0000};
    vec[2] = '{5'd16, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    vec[3] = '{5'd1,  64'h5A5A_5A5A_A5A5_A5A5, 64'h5A5A_5A5A_A5A5_A5A5};
    vec[4] = '{5'd31, 64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0000};
    vec[5] = '{5'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    rst0 = 1'b1; rst2 = 1'b1;
    if0.address_a = '0; if0.data_a = '0; if0.address_b = '0; if0.data_b = '0;
    idle0();
    if2.address_a = '0; if2.data_a = '0; if2.address_b = '0; if2.data_b = '0;
    if2.wren_a = 1'b0; if2.rden_a = 1'b0; if2.wren_b = 1'b0; if2.rden_b = 1'b0;
    step(); step();

    // reset values
    chk("rst_out_a", if0.out_a, 64'h0);
    chk("rst_out_b", if0.out_b, 64'h0);
    chk("rst_rvalid", {if0.rvalid_a, if0.rvalid_b}, 64'h0);
    chk("rst_collision", if0.collision, 64'h0);
    chk("rst_busy_clear", if0.busy, 64'h1);
    chk("rst_busy_noclear", if2.busy, 64'h0);
    chk("rst_out_noclear", if2.out_a, 64'h0);

    rst0 = 1'b0;
    count_busy(n0, n1);
    chk("clear_len0", 64'(n0), 64'd32);
    chk("clear_len1", 64'(n1), 64'd32);

    // preload word 5, then flush an in-flight read with reset
    wr_a(5'd5, 64'hAA);
    rd_b(5'd5, 64'hAA, 64'hAA);
    repeat (4) step();
    if0.address_b = 5'd5; if0.rden_b = 1'b1;
    step();
    if0.rden_b = 1'b0; rst0 = 1'b1;
    step();

    // traffic during clear is ignored; reset again at cycle 10 of clear
    rst0 = 1'b0;
    if0.address_a = 5'd0; if0.data_a = 64'hFF; if0.wren_a = 1'b1; if0.rden_a = 1'b1;
    if0.address_b = 5'd0; if0.rden_b = 1'b1;
    repeat (10) step();
    chk("clear_no_rvalid", {if0.rvalid_a, if0.rvalid_b, if1.rvalid_a, if1.rvalid_b}, 64'h0);
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    count_busy(n0, n1);
    idle0();
    chk("midclear_len0", 64'(n0), 64'd32);
    chk("midclear_len1", 64'(n1), 64'd32);
    rd_b(5'd0, 64'h0, 64'h0);
    rd_b(5'd5, 64'h0, 64'h0);

    // write then read on the other port: 3-cycle latency
    wr_a(5'd3, 64'h1234);
    rd_b(5'd3, 64'h1234, 64'h1234);
    repeat (4) step();

    // dual write same address: A wins, collision pulses once
    if0.address_a = 5'd7; if0.data_a = 64'h11; if0.wren_a = 1'b1;
    if0.address_b = 5'd7; if0.data_b = 64'h22; if0.wren_b = 1'b1;
    step();
    idle0();
    chk("collision_pulse0", if0.collision, 64'h1);
    chk("collision_pulse1", if1.collision, 64'h1);
    step();
    chk("collision_drop", if0.collision, 64'h0);
    rd_a(5'd7, 64'h11, 64'h11);

    if0.address_a = 5'd8; if0.data_a = 64'h88; if0.wren_a = 1'b1;
    if0.address_b = 5'd10; if0.data_b = 64'hA0; if0.wren_b = 1'b1;
    step();
    idle0();
    chk("collision_diff_addr", if0.collision, 64'h0);

    // cross-port read during write: old data vs forwarded data
    wr_a(5'd9, 64'h33);
    if0.address_a = 5'd9; if0.data_a = 64'h55; if0.wren_a = 1'b1;
    if0.address_b = 5'd9; if0.rden_b = 1'b1;
    push(1, 64'h33, 2); push(3, 64'h55, 2);
    step();
    idle0();
    chk("rdw_no_collision0", if0.collision, 64'h0);
    chk("rdw_no_collision1", if1.collision, 64'h0);
    rd_b(5'd9, 64'h55, 64'h55);

    // same-port read right after own write; write+read on one port gives no rvalid
    wr_a(5'd12, 64'hBEEF);
    rd_a(5'd12, 64'hBEEF, 64'hBEEF);
    if0.address_a = 5'd13; if0.data_a = 64'h1313; if0.wren_a = 1'b1; if0.rden_a = 1'b1;
    step();
    idle0();
    rd_a(5'd13, 64'h1313, 64'h1313);
    repeat (4) step();

    // table: write all via A, then read back on both ports every cycle
    foreach (vec[i]) wr_a(vec[i].addr, vec[i].wdata);
    foreach (vec[i]) begin
      if0.address_a = vec[i].addr;   if0.rden_a = 1'b1;
      if0.address_b = vec[5-i].addr; if0.rden_b = 1'b1;
      push(0, vec[i].exp, 2);   push(2, vec[i].exp, 2);
      push(1, vec[5-i].exp, 2); push(3, vec[5-i].exp, 2);
      step();
    end
    idle0();
    repeat (5) step();

    // DEPTH=20 instance: no clear, out-of-range, full-rate reads
    rst2 = 1'b0;
    step();
    chk("noclear_busy", if2.busy, 64'h0);
    for (int i = 0; i < 20; i++) begin
      if2.address_a = 5'(i); if2.data_a = 64'h1000 + 64'(i); if2.wren_a = 1'b1;
      step();
    end
    if2.address_a = 5'd25; if2.data_a = 64'h77;
    step();
    if2.wren_a = 1'b0;
    if2.address_b = 5'd25; if2.rden_b = 1'b1;
    push(5, 64'h0, 1);
    step();
    if2.rden_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if2.address_a = 5'(i); if2.rden_a = 1'b1;
      push(4, 64'h1000 + 64'(i), 1);
      step();
    end
    if2.rden_a = 1'b0;
    repeat (5) step();

    for (int i = 0; i < 6; i++) chk($sformatf("sb_drained_p%0d", i), 64'(sb[i].size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dpram_param.md
Name: dpram_param

Overview:
- Parametrised true dual-port RAM for attention/softmax vector buffers; successor to the fixed 32-word dual-port buffer.
- Adds configurable width and depth, separate read enables, a registered output pipeline with aligned read-valid, and a defined cross-port collision policy.
- Adds an optional post-reset memory clear sequencer with a busy flag.
- Sits between the vector datapath and the host/load engines wherever a 2-port vector store is needed.

Parameters:
- DATA_W, 64: word width in bits.
- DEPTH, 32: number of words; need not be a power of two.
- ADDR_W, 5: address width; must satisfy 2**ADDR_W >= DEPTH.
- OUT_STAGES, 0: extra output register stages (0..2) after the RAM read register.
- RDW_NEW, 0: cross-port read-during-write policy. 0 = read returns old data; 1 = read returns the data being written.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset before accepting traffic.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- busy  out  1  clear sequence in progress; port traffic is ignored while high.
- address_a  in  ADDR_W  port A address.
- wren_a  in  1  port A write enable.
- rden_a  in  1  port A read enable.
- data_a  in  DATA_W  port A write data.
- out_a  out  DATA_W  port A read data.
- rvalid_a  out  1  out_a carries a new read result this cycle.
- address_b, wren_b, rden_b, data_b, out_b, rvalid_b: same as port A, for port B.
- collision  out  1  one-cycle pulse: both ports wrote the same address.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: out_a = out_b = 0, rvalid_a = rvalid_b = 0, collision = 0, and all pipeline stages are cleared.
- busy after reset: goes to 1 on the cycle after reset is sampled high if CLEAR_ON_RESET = 1, otherwise 0.
- State machine: CLEAR and RUN.
  - Reset enters CLEAR with clear counter = 0 if CLEAR_ON_RESET = 1, otherwise RUN.
  - CLEAR: writes 0 to word[counter] each cycle and increments the counter.
  - CLEAR to RUN: after the write to word DEPTH-1. busy is 1 for exactly DEPTH cycles.
  - CLEAR ignores wren and rden on both ports; no rvalid is produced.
  - Reset asserted mid-CLEAR restarts the counter at 0.
  - Reset asserted in RUN flushes in-flight reads (their rvalid never appears).
- Write: when wren_x = 1, word[address_x] is updated at the clock edge. Write has priority over read on the same port: wren_x = rden_x = 1 performs the write only, with no rvalid.
- Read:
  - rden_x = 1 with wren_x = 0 issues a read.
  - Result appears on out_x with rvalid_x = 1 exactly 1 + OUT_STAGES cycles later.
  - Back-to-back reads are accepted every cycle (full throughput).
  - With no read issued, out_x holds its last value and rvalid_x = 0.
- Same address, both ports writing: port A data is stored and collision pulses 1 in the following cycle. Writes to different addresses never flag collision.
- Same address, one port reading while the other writes:
  - RDW_NEW = 0: the read returns the pre-write contents.
  - RDW_NEW = 1: the read returns the write data (forwarded).
  - collision is not asserted.
- Same port reading after its own write: a read issued on the cycle after a write returns the written data.
- Out of range (address >= DEPTH, only possible when DEPTH is not a power of two):
  - A write is dropped with no memory change.
  - A read returns 0 with rvalid asserted normally.
- Width rules: no arithmetic on data. The clear counter is ADDR_W bits and its terminal compare is against DEPTH-1.
- Synthesis: the storage array is inferred. The forwarding and collision logic is outside the array so it maps to block RAM.

Decomposition:
- Shared package dpram_pkg holds:
  - the state enum (ST_CLEAR, ST_RUN);
  - RDW_OLD = 0 and RDW_NEW = 1 constants;
  - the maximum OUT_STAGES (2).
- One sub-module, dpram_out_pipe: a per-port delay line carrying {valid, data}, OUT_STAGES deep, reset to 0. It is instantiated once per port.

Test Plan:
- Reset clear: DEPTH=32, CLEAR_ON_RESET=1, pulse reset, preload word 5 = 0xAA before reset → busy is high for exactly 32 cycles; a subsequent read of word 5 returns 0.
- Latency: OUT_STAGES=2, write A addr 3 = 0x1234, then read B addr 3 → out_b = 0x1234 with rvalid_b = 1 exactly 3 cycles after rden_b; rvalid_b is a one-cycle pulse.
- Dual write: both ports write addr 7 in the same cycle, A = 0x11, B = 0x22 → collision = 1 next cycle; a read of addr 7 returns 0x11.
- Read-during-write: A writes addr 9 = 0x55 (old value 0x33) while B reads addr 9 → RDW_NEW=0 gives out_b = 0x33; RDW_NEW=1 gives out_b = 0x55.
- Busy ignore and mid-clear reset: issue wren_a addr 0 = 0xFF and rden_b during CLEAR → no rvalid, and word 0 reads 0 after clear. Re-assert reset at cycle 10 of CLEAR → busy stays high 32 more cycles.
- Out of range and throughput: DEPTH=20, write addr 25 = 0x77, then read 25 → returns 0. Reads of addrs 0..19 issued on consecutive cycles → 20 consecutive rvalid pulses in order.
